// File: rtl/ps2_key_pkg.sv
// Shared PS/2 key-event definitions used by the encoder and the keyboard decoder.
package ps2_key_pkg;

  localparam int unsigned KEY_STROBE_BIT  = 10;
  localparam int unsigned KEY_PRESSED_BIT = 9;
  localparam int unsigned KEY_EXT_BIT     = 8;
  localparam int unsigned KEY_CODE_W      = 8;
  localparam int unsigned KEY_W           = KEY_STROBE_BIT + 1;
  localparam int unsigned KEY_ENTRY_W     = KEY_CODE_W + 1;

  // One queued key event: {pressed, extended, scancode}
  typedef struct packed {
    logic                  pressed;
    logic                  ext;
    logic [KEY_CODE_W-1:0] code;
  } ps2_evt_t;

  localparam int unsigned EVT_W = $bits(ps2_evt_t);

  // Bit width able to index n items, never narrower than one bit
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Small synchronous first-word fall-through FIFO for queued key events.
module ps2_evt_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          push_ok;
  logic          pop_ok;

  // A pop frees a slot in the same cycle, so a full FIFO may still accept a push alongside it
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata_c = mem[rd_ptr];

  // Next occupancy
  always_comb begin
    level_nxt = level;
    if (push_ok && !pop_ok) begin
      level_nxt = level + LW'(1);
    end else if (!push_ok && pop_ok) begin
      level_nxt = level - LW'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LW'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

endmodule

// File: rtl/ps2_key_encoder.sv
// Turns level key states into a paced stream of PS/2 toggle-strobe key events.
module ps2_key_encoder
  import ps2_key_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                            clk_sys,
  input  logic                            reset_n,
  input  logic [NUM_KEYS-1:0]             keys,
  input  logic [KEY_ENTRY_W*NUM_KEYS-1:0] key_codes,
  output logic [KEY_W-1:0]                ps2_key,
  output logic                            pending,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned IW = min1_clog2(NUM_KEYS);
  localparam int unsigned GW = min1_clog2(GAP_CYCLES);

  logic [IW-1:0]          scan_idx;
  logic [NUM_KEYS-1:0]    reported;
  logic [GW-1:0]          gap_cnt;
  logic                   key_now_c;
  logic                   rep_now_c;
  logic [KEY_ENTRY_W-1:0] entry_c;
  logic                   push_c;
  logic                   pop_c;
  ps2_evt_t               push_evt_c;
  logic [EVT_W-1:0]       head_c;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Select the level, last reported state and code of the key under scan
  always_comb begin
    key_now_c = 1'b0;
    rep_now_c = 1'b0;
    entry_c   = '0;
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (scan_idx == IW'(k)) begin
        key_now_c = keys[k];
        rep_now_c = reported[k];
        entry_c   = key_codes[KEY_ENTRY_W*k +: KEY_ENTRY_W];
      end
    end
  end

  // Event for the scanned key; a full FIFO defers it to the next scan of that key
  always_comb begin
    push_evt_c         = '0;
    push_evt_c.pressed = key_now_c;
    push_evt_c.ext     = entry_c[KEY_CODE_W];
    push_evt_c.code    = entry_c[KEY_CODE_W-1:0];
  end

  assign push_c  = (key_now_c != rep_now_c) && !fifo_full;
  assign pop_c   = !fifo_empty && (gap_cnt == '0);
  assign pending = !fifo_empty;

  // Scanner: walk the keys and remember the state last queued for each
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      scan_idx <= '0;
      reported <= '0;
    end else begin
      scan_idx <= (scan_idx == IW'(NUM_KEYS - 1)) ? '0 : scan_idx + IW'(1);
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (push_c && (scan_idx == IW'(k))) begin
          reported[k] <= key_now_c;
        end
      end
    end
  end

  // Emitter: present the head event with a fresh strobe, then hold off GAP_CYCLES
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key <= '0;
      gap_cnt <= '0;
    end else if (pop_c) begin
      ps2_key <= {~ps2_key[KEY_STROBE_BIT], head_c};
      gap_cnt <= GW'(GAP_CYCLES - 1);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (clk_sys),
    .rst_n   (reset_n),
    .push    (push_c),
    .wdata   (push_evt_c),
    .pop     (pop_c),
    .rdata_c (head_c),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Directed bench for ps2_key_encoder: latency, pacing, ordering, overflow retry, reset.
module tb_ps2_key_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  keys = 4'h0;
  logic [3:0]  keys2 = 4'h0;
  logic [35:0] codes = {9'h02E, 9'h016, 9'h175, 9'h029};
  logic [10:0] ps2_key;
  logic [10:0] ps2_key2;
  logic        pending;
  logic        pending2;
  logic [2:0]  level;
  logic [1:0]  level2;
  logic [1:0]  tb_idx;
  int          checks = 0;
  int          errors = 0;

  ps2_key_encoder #(.NUM_KEYS(4), .FIFO_DEPTH(4), .GAP_CYCLES(16)) dut (
    .clk_sys(clk), .reset_n(rst_n), .keys(keys), .key_codes(codes),
    .ps2_key(ps2_key), .pending(pending), .fifo_level(level)
  );

  ps2_key_encoder #(.NUM_KEYS(4), .FIFO_DEPTH(2), .GAP_CYCLES(16)) dut2 (
    .clk_sys(clk), .reset_n(rst_n), .keys(keys2), .key_codes(codes),
    .ps2_key(ps2_key2), .pending(pending2), .fifo_level(level2)
  );

  always #5 clk = ~clk;

  // Which key the scanner visits in the current cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_idx <= 2'd0;
    else        tb_idx <= (tb_idx == 2'd3) ? 2'd0 : tb_idx + 2'd1;
  end

  // Advance (at negedges) to the cycle where key k is scanned
  task automatic wait_slot(input logic [1:0] k);
    for (int i = 0; i < 8; i++) begin
      if (tb_idx == k) break;
      @(negedge clk);
    end
  endtask

  // Wait for the next strobe toggle on the main DUT, bounded
  task automatic wait_toggle(output logic [10:0] val, output bit ok);
    logic s0;
    s0  = ps2_key[10];
    ok  = 1'b0;
    val = ps2_key;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ps2_key[10] !== s0) begin
        ok  = 1'b1;
        val = ps2_key;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [10:0] seen_key;
    logic        seen_pend;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ps2_key !== 11'h000) begin errors++; $display("FAIL reset_key got %h want 000", ps2_key); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (ps2_key2 !== 11'h000) begin errors++; $display("FAIL reset_key2 got %h want 000", ps2_key2); end
    seen_key  = 11'h000;
    seen_pend = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seen_key  = seen_key | ps2_key;
      seen_pend = seen_pend | pending;
    end
    checks++; if (seen_key !== 11'h000) begin errors++; $display("FAIL idle_key got %h want 000", seen_key); end
    checks++; if (seen_pend !== 1'b0) begin errors++; $display("FAIL idle_pending got %b want 0", seen_pend); end
  endtask

  task automatic test_press();
    logic [10:0] v;
    bit          ok;
    wait_slot(2'd0);
    keys[0] = 1'b1;
    @(negedge clk);
    checks++; if (ps2_key !== 11'h000) begin errors++; $display("FAIL press_early got %h want 000", ps2_key); end
    @(negedge clk);
    checks++; if (ps2_key !== 11'h629) begin errors++; $display("FAIL press_key0 got %h want 629", ps2_key); end
    keys[0] = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (ps2_key !== 11'h629) begin errors++; $display("FAIL hold_key0 got %h want 629", ps2_key); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL release_queued got %b want 1", pending); end
    wait_toggle(v, ok);
    checks++; if (!ok || v !== 11'h029) begin errors++; $display("FAIL release_key0 got %h ok %b want 029", v, ok); end
  endtask

  task automatic test_extended();
    logic [10:0] v;
    bit          ok;
    keys[1] = 1'b1;
    wait_toggle(v, ok);
    checks++; if (!ok || v !== 11'h775) begin errors++; $display("FAIL press_ext got %h ok %b want 775", v, ok); end
    keys[1] = 1'b0;
    wait_toggle(v, ok);
    checks++; if (!ok || v !== 11'h175) begin errors++; $display("FAIL release_ext got %h ok %b want 175", v, ok); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [10:0] exp_on [4];
    logic [10:0] exp_off [4];
    logic [10:0] got [4];
    int          at [4];
    int          n;
    int          peak;
    logic        prev;
    logic [10:0] v;
    bit          ok;
    exp_on  = '{11'h629, 11'h375, 11'h616, 11'h22E};
    exp_off = '{11'h429, 11'h175, 11'h416, 11'h02E};
    got = '{default: 11'h0};
    at  = '{default: 0};
    n = 0;
    peak = 0;
    wait_slot(2'd0);
    prev = ps2_key[10];
    keys = 4'hF;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
      if (ps2_key[10] !== prev) begin
        if (n < 4) begin
          got[n] = ps2_key;
          at[n]  = c;
        end
        n++;
        prev = ps2_key[10];
      end
    end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got[i] !== exp_on[i]) begin errors++; $display("FAIL b2b_order[%0d] got %h want %h", i, got[i], exp_on[i]); end
    end
    checks++; if (at[0] != 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", at[0]); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (at[i] - at[i-1] != 16) begin errors++; $display("FAIL b2b_gap[%0d] got %0d want 16", i, at[i] - at[i-1]); end
    end
    checks++; if (peak < 3 || peak > 4) begin errors++; $display("FAIL b2b_peak got %0d want 3..4", peak); end
    keys = 4'h0;
    for (int i = 0; i < 4; i++) begin
      wait_toggle(v, ok);
      checks++; if (!ok || v !== exp_off[i]) begin errors++; $display("FAIL b2b_release[%0d] got %h ok %b want %h", i, v, ok, exp_off[i]); end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_overflow();
    int   tog;
    int   peak;
    logic prev;
    tog  = 0;
    peak = 0;
    wait_slot(2'd1);
    prev = ps2_key2[10];
    keys2 = 4'hF;
    @(negedge clk);
    @(negedge clk);
    keys2 = 4'h0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (int'(level2) > peak) peak = int'(level2);
      if (ps2_key2[10] !== prev) begin
        tog++;
        prev = ps2_key2[10];
      end
    end
    checks++; if (tog != 4) begin errors++; $display("FAIL ovf_toggles got %0d want 4", tog); end
    checks++; if (ps2_key2 !== 11'h016) begin errors++; $display("FAIL ovf_final got %h want 016", ps2_key2); end
    checks++; if (peak != 2) begin errors++; $display("FAIL ovf_peak got %0d want 2", peak); end
    checks++; if (pending2 !== 1'b0 || level2 !== 2'd0) begin errors++; $display("FAIL ovf_drained got pending %b level %0d want 0 0", pending2, level2); end
  endtask

  task automatic test_glitch();
    int   tog;
    logic prev;
    logic pend_seen;
    tog = 0;
    pend_seen = 1'b0;
    wait_slot(2'd0);
    prev = ps2_key[10];
    keys[2] = 1'b1;
    @(negedge clk);
    keys[2] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      pend_seen = pend_seen | pending;
      if (ps2_key[10] !== prev) begin
        tog++;
        prev = ps2_key[10];
      end
    end
    checks++; if (tog != 0 || pend_seen !== 1'b0) begin errors++; $display("FAIL glitch got toggles %0d pending %b want 0 0", tog, pend_seen); end
  endtask

  task automatic test_reset_mid();
    int          tog;
    logic        prev;
    logic [10:0] first;
    wait_slot(2'd0);
    keys = 4'hF;
    repeat (4) @(negedge clk);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level got %0d want 3", level); end
    checks++; if (ps2_key !== 11'h629) begin errors++; $display("FAIL mid_key got %h want 629", ps2_key); end
    keys  = 4'h8;
    rst_n = 1'b0;
    #1;
    checks++; if (ps2_key !== 11'h000) begin errors++; $display("FAIL mid_reset_key got %h want 000", ps2_key); end
    checks++; if (pending !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL mid_reset_fifo got pending %b level %0d want 0 0", pending, level); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tog   = 0;
    prev  = ps2_key[10];
    first = 11'h000;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ps2_key[10] !== prev) begin
        if (tog == 0) first = ps2_key;
        tog++;
        prev = ps2_key[10];
      end
    end
    checks++; if (tog != 1) begin errors++; $display("FAIL post_reset_count got %0d want 1", tog); end
    checks++; if (first !== 11'h62E) begin errors++; $display("FAIL post_reset_key got %h want 62E", first); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_extended();
    test_back_to_back();
    test_overflow();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/ps2_key_encoder.md
Name: ps2_key_encoder

Overview:
- Generates the 11-bit toggle-strobe key-event interface that the core's keyboard decoder consumes: ps2_key[10] is a toggle strobe, [9] is pressed, [8] is extended, [7:0] is the scancode.
- Converts a vector of level-sensitive key/button states into a paced stream of press/release events.
- Used to inject keyboard events from joystick or user-port sources, and as the stimulus source for decoder benches.
- Sits between the input sources and the keyboard decoder in the emu top level.

Parameters:
- NUM_KEYS, 8, number of key inputs; range 1..32.
- FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2.
- GAP_CYCLES, 16, minimum clk_sys cycles between successive ps2_key strobe toggles; at least 1.

Ports:
- clk_sys  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- keys  input  NUM_KEYS  current key levels, 1 = held; synchronous to clk_sys.
- key_codes  input  9*NUM_KEYS  per-key {extended, scancode}; key i occupies bits [9i+8:9i]; treated as static.
- ps2_key  output  11  {strobe, pressed, extended, code[7:0]}.
- pending  output  1  FIFO not empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset state (async assert, sync deassert is the integrator's responsibility):
  - ps2_key = 0, pending = 0, fifo_level = 0.
  - reported[NUM_KEYS-1:0] = 0, scan index = 0, gap counter = 0, FIFO empty.
- Scanner:
  - Index i advances one key per cycle, 0..NUM_KEYS-1, and wraps to 0.
  - If keys[i] != reported[i] and the FIFO is not full: push {keys[i], key_codes[i]} and set reported[i] = keys[i] in the same cycle.
  - If the FIFO is full: do not push and leave reported[i] unchanged. The key is retried on its next scan, so a final state is never lost.
  - A press and release that both occur between two scans of the same key produce no event (coalesced). This is the intended behaviour.
- FIFO:
  - Synchronous and first-word fall-through internally. A push is visible to the emitter on the next cycle.
  - Simultaneous push and pop is allowed and leaves the level unchanged, including when the FIFO is full (the pop frees the slot that cycle).
  - Never overflows and never underflows.
- Emitter:
  - Pops when the FIFO is not empty and the gap counter is 0.
  - On pop, registers ps2_key[9:0] = the popped event, ps2_key[10] = ~ps2_key[10], and gap counter = GAP_CYCLES-1.
  - The gap counter decrements to 0 and saturates there.
  - Result: consecutive toggles are exactly GAP_CYCLES apart under backlog.
  - ps2_key[9:0] holds its value between pops.
- Latency:
  - Push in scan cycle t, pop in t+1, ps2_key changes at the t+2 edge.
  - Worst case from a keys change to the strobe is NUM_KEYS+1 cycles plus queueing.
- Ordering:
  - Events leave in push order.
  - Within one scan pass, lower index first among keys that changed before their scan slot.
- Reset mid-operation:
  - Queued events are discarded and the strobe returns to 0.
  - Keys held across reset produce fresh press events after reset, because reported is cleared.
- Width rules:
  - Scan index is $clog2(NUM_KEYS) bits (min 1) and wraps explicitly at NUM_KEYS-1, not at a power of two.
  - fifo_level counts 0..FIFO_DEPTH.

Decomposition:
- Shared package ps2_key_pkg:
  - Bit-position constants: KEY_STROBE_BIT = 10, KEY_PRESSED_BIT = 9, KEY_EXT_BIT = 8, KEY_CODE_W = 8.
  - Typedef ps2_evt_t (10-bit {pressed, ext, code}).
  - The same package is reused by the existing keyboard decoder.
- One sub-module: ps2_evt_fifo (parameterised depth, width = $bits(ps2_evt_t), push/pop/full/empty/level).
- Scanner and emitter live in ps2_key_encoder.

Test Plan:
- Common setup: NUM_KEYS = 4, FIFO_DEPTH = 4, GAP_CYCLES = 16; codes key0 = 9'h029, key1 = 9'h175, key2 = 9'h016, key3 = 9'h02E.
- Reset then idle with keys = 0 -> ps2_key stays 11'h000 and pending = 0 for 100 cycles.
- Set keys[0] = 1 at the scan-0 cycle -> two cycles later ps2_key = 11'h629 (strobe 1, pressed 1, code 29). Clear keys[0] -> next event is 11'h029 (strobe 0).
- Set keys[1] = 1 -> ps2_key = {1, 1, 1, 8'h75} = 11'h775. The extended bit propagates.
- Set all four keys in one cycle -> four events in index order 0, 1, 2, 3; strobe toggles exactly 16 cycles apart; fifo_level peaks at 3 or 4 and never exceeds 4.
- Overflow/no-loss: FIFO_DEPTH = 2, toggle all four keys on then off within 2 cycles -> every key's final state is eventually reported; strobe toggle count is even; reported == keys at the end.
- Glitch and reset:
  - Pulse keys[2] for 1 cycle outside its scan slot -> no event.
  - Assert reset_n = 0 with 3 events queued and keys[3] held -> ps2_key = 0 immediately. After release, exactly one event 11'h62E.
